// File: rtl/rotaciona_linhas_cripta_seq.sv
// rotaciona_linhas_cripta_seq
// Encrypt-side row rotation. The 128-bit block is handled as four 32-bit rows
// (row0 = [127:96] ... row3 = [31:0]). Row r is rotated LEFT by r bytes.
// One row is processed per clock, and the full 4-row pass repeats ROUNDS times.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   bloco           input block
//   bloco_valido    input block valid
//   bloco_pronto    ready to accept a block (high only while idle)
//   saida           rotated block (taken directly from the working register)
//   saida_valida    result valid
//   saida_pronta    downstream ready
//   contador_blocos completed output handshakes, wraps at 2^CNT_W
module rotaciona_linhas_cripta_seq #(
   parameter int ROUNDS = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [127:0]     bloco,
   input  logic             bloco_valido,
   output logic             bloco_pronto,
   output logic [127:0]     saida,
   output logic             saida_valida,
   input  logic             saida_pronta,
   output logic [CNT_W-1:0] contador_blocos
);

   localparam int RW = $clog2(ROUNDS) + 1;

   if (ROUNDS < 1) begin : g_rounds_invalid
      $error("rotaciona_linhas_cripta_seq: ROUNDS must be >= 1");
   end

   typedef enum logic [1:0] {OCIOSO, ROTACIONA, PRONTO} estado_t;

   estado_t          estado;
   estado_t          prox;
   logic [127:0]     trab;
   logic [127:0]     trab_rot;
   logic [1:0]       linha;
   logic [RW-1:0]    rodada;
   logic [CNT_W-1:0] cont;
   logic [31:0]      sel;
   logic [31:0]      rot;
   logic             ultima;

   // Last rotation step: row 3 of the final round.
   assign ultima = (linha == 2'd3) && (rodada == RW'(ROUNDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= OCIOSO;
      else        estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:    if (bloco_valido) prox = ROTACIONA;
         ROTACIONA: if (ultima)       prox = PRONTO;
         PRONTO:    if (saida_pronta) prox = OCIOSO;
         default:                     prox = OCIOSO;
      endcase
   end

   // Row r sits at bit offset (3-r)*32, which is {~r, 5'b0} for a 2-bit r.
   always_comb begin
      sel = trab[{~linha, 5'd0} +: 32];
      case (linha)
         2'd0:    rot = sel;
         2'd1:    rot = {sel[23:0], sel[31:24]};
         2'd2:    rot = {sel[15:0], sel[31:16]};
         default: rot = {sel[7:0],  sel[31:8]};
      endcase
      trab_rot = trab;
      trab_rot[{~linha, 5'd0} +: 32] = rot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trab   <= '0;
         linha  <= '0;
         rodada <= '0;
         cont   <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (bloco_valido) begin
                  trab   <= bloco;
                  linha  <= '0;
                  rodada <= '0;
               end
            end
            ROTACIONA: begin
               trab  <= trab_rot;
               linha <= linha + 2'd1;
               if (linha == 2'd3) rodada <= rodada + 1'b1;
            end
            PRONTO: begin
               if (saida_pronta) cont <= cont + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bloco_pronto    = (estado == OCIOSO);
   assign saida_valida    = (estado == PRONTO);
   assign saida           = trab;
   assign contador_blocos = cont;

endmodule

// File: tb/tb_rotaciona_linhas_cripta_seq.sv
module tb_rotaciona_linhas_cripta_seq;

   localparam logic [127:0] BASIC_IN  = 128'h505645434941525354464c4154455241;
   localparam logic [127:0] BASIC_EXP = 128'h50564543415253494c41544641544552;
   localparam logic [127:0] RT_IN     = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] RT_EXP    = 128'h00010203_05060704_0a0b0809_0f0c0d0e;
   localparam logic [127:0] R2_EXP    = 128'h00010203_06070405_08090a0b_0e0f0c0d;
   localparam logic [127:0] BP_IN     = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] BP_EXP    = 128'h00112233_55667744_aabb8899_ffccddee;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [127:0] bloco = '0;

   logic va = 1'b0, pa = 1'b0, bpa, sva;
   logic [127:0] sa;
   logic [15:0]  ca;
   logic vb = 1'b0, pb = 1'b0, bpb, svb;
   logic [127:0] sb;
   logic [15:0]  cb;
   logic vc = 1'b0, pc = 1'b0, bpc, svc;
   logic [127:0] sc;
   logic [15:0]  cc;
   logic vd = 1'b0, pd = 1'b0, bpd, svd;
   logic [127:0] sd;
   logic [1:0]   cd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rotaciona_linhas_cripta_seq #(.ROUNDS(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bloco(bloco), .bloco_valido(va), .bloco_pronto(bpa),
      .saida(sa), .saida_valida(sva), .saida_pronta(pa), .contador_blocos(ca));
   rotaciona_linhas_cripta_seq #(.ROUNDS(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bloco(bloco), .bloco_valido(vb), .bloco_pronto(bpb),
      .saida(sb), .saida_valida(svb), .saida_pronta(pb), .contador_blocos(cb));
   rotaciona_linhas_cripta_seq #(.ROUNDS(4), .CNT_W(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .bloco(bloco), .bloco_valido(vc), .bloco_pronto(bpc),
      .saida(sc), .saida_valida(svc), .saida_pronta(pc), .contador_blocos(cc));
   rotaciona_linhas_cripta_seq #(.ROUNDS(1), .CNT_W(2)) dut_d (
      .clk(clk), .rst_n(rst_n), .bloco(bloco), .bloco_valido(vd), .bloco_pronto(bpd),
      .saida(sd), .saida_valida(svd), .saida_pronta(pd), .contador_blocos(cd));

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic valid_of(input int which);
      case (which)
         0:       return sva;
         1:       return svb;
         2:       return svc;
         default: return svd;
      endcase
   endfunction

   // Counts falling edges until the selected instance shows a valid result.
   task automatic wait_valid(input int which, output int lat);
      lat = 0;
      while (valid_of(which) !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
   endtask

   initial begin
      int lat;
      logic stable;
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic ok;

      // Reset state
      step(); step();
      chk("rst_pronto", 128'(bpa), 128'(1'b1));
      chk("rst_valida", 128'(sva), 128'(1'b0));
      chk("rst_saida", sa, '0);
      chk("rst_cont", 128'(ca), '0);
      rst_n = 1'b1;
      step();

      // Basic block, ROUNDS=1
      bloco = BASIC_IN; va = 1'b1; pa = 1'b1;
      step();
      va = 1'b0;
      chk("basic_busy", 128'(bpa), 128'(1'b0));
      wait_valid(0, lat);
      chk("basic_lat", 128'(lat), 128'(4));
      chk("basic_out", sa, BASIC_EXP);
      step();
      chk("basic_cnt", 128'(ca), 128'(1));
      chk("basic_valid_drop", 128'(sva), 128'(1'b0));
      chk("basic_ready_back", 128'(bpa), 128'(1'b1));
      chk("basic_out_hold", sa, BASIC_EXP);

      // Round-trip block
      bloco = RT_IN; va = 1'b1;
      step();
      va = 1'b0;
      wait_valid(0, lat);
      chk("rt_lat", 128'(lat), 128'(4));
      chk("rt_out", sa, RT_EXP);
      step();
      chk("rt_cnt", 128'(ca), 128'(2));

      // Backpressure with a second block presented
      pa = 1'b0; bloco = BP_IN; va = 1'b1;
      step();
      va = 1'b0;
      wait_valid(0, lat);
      chk("bp_lat", 128'(lat), 128'(4));
      chk("bp_out", sa, BP_EXP);
      bloco = BASIC_IN; va = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (sa !== BP_EXP || bpa !== 1'b0 || sva !== 1'b1) ok = 1'b0;
      end
      chk("bp_hold", 128'(ok), 128'(1'b1));
      chk("bp_cnt_held", 128'(ca), 128'(2));
      pa = 1'b1;
      step();
      chk("bp_ready_after", 128'(bpa), 128'(1'b1));
      chk("bp_valid_after", 128'(sva), 128'(1'b0));
      chk("bp_cnt", 128'(ca), 128'(3));
      step();
      va = 1'b0;
      chk("bp2_busy", 128'(bpa), 128'(1'b0));
      wait_valid(0, lat);
      chk("bp2_lat", 128'(lat), 128'(4));
      chk("bp2_out", sa, BASIC_EXP);
      step();
      chk("bp2_cnt", 128'(ca), 128'(4));

      // Reset in the middle of an operation
      bloco = RT_IN; va = 1'b1;
      step();
      va = 1'b0;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pronto", 128'(bpa), 128'(1'b1));
      chk("mid_rst_valida", 128'(sva), 128'(1'b0));
      chk("mid_rst_saida", sa, '0);
      chk("mid_rst_cont", 128'(ca), '0);
      step();
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (sva !== 1'b0) ok = 1'b0;
      end
      chk("mid_rst_no_stale", 128'(ok), 128'(1'b1));
      bloco = BASIC_IN; va = 1'b1;
      step();
      va = 1'b0;
      wait_valid(0, lat);
      chk("post_rst_lat", 128'(lat), 128'(4));
      chk("post_rst_out", sa, BASIC_EXP);
      step();
      chk("post_rst_cnt", 128'(ca), 128'(1));

      // ROUNDS=2
      bloco = RT_IN; vb = 1'b1; pb = 1'b1;
      step();
      vb = 1'b0;
      wait_valid(1, lat);
      chk("r2_lat", 128'(lat), 128'(8));
      chk("r2_out", sb, R2_EXP);
      step();
      chk("r2_cnt", 128'(cb), 128'(1));

      // ROUNDS=4 returns the input
      bloco = RT_IN; vc = 1'b1; pc = 1'b1;
      step();
      vc = 1'b0;
      wait_valid(2, lat);
      chk("r4_lat", 128'(lat), 128'(16));
      chk("r4_out", sc, RT_IN);
      step();
      chk("r4_cnt", 128'(cc), 128'(1));

      // CNT_W=2 wrap with back-to-back blocks
      bloco = RT_IN; vd = 1'b1; pd = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         wait_valid(3, lat);
         chk($sformatf("wrap_period_%0d", k), 128'(lat), 128'(5));
         chk($sformatf("wrap_out_%0d", k), sd, RT_EXP);
         step();
         chk($sformatf("wrap_cnt_%0d", k), 128'(cd), 128'(k % 4));
      end
      vd = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
